// File: rtl/def_bus_driver.sv
// Latches a 13-bit word, drives its fields with a one-cycle strobe and waits
// for an acknowledge, re-driving on timeout up to MAX_RETRY times.
module def_bus_driver #(
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_data,
  output logic [1:0]  signal_d,
  output logic [2:0]  signal_e,
  output logic [3:0]  signal_e2,
  output logic [3:0]  signal_e3,
  output logic        drv_strobe,
  input  logic        signal_f,
  output logic        done,
  output logic        err,
  output logic [1:0]  retries
);

  // state    | meaning
  // IDLE     | ready for a word; done/err pulse here after a transfer ends
  // DRIVE    | one-cycle strobe of the latched fields; ack ignored
  // WAIT_ACK | counting TIMEOUT cycles for signal_f
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_ACK} state_t;

  localparam int             CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TC = CW'(TIMEOUT - 1);
  localparam logic [1:0]     MR = 2'(MAX_RETRY);

  state_t        state, state_nxt;
  logic [12:0]   fields;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    retry_cnt;
  logic          done_q, err_q;
  logic          timeout, can_retry;

  // ack wins over a timeout in the same cycle
  assign timeout   = (state == WAIT_ACK) && !signal_f && (wait_cnt == TC);
  assign can_retry = retry_cnt < MR;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = DRIVE;
      DRIVE:    state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (signal_f)     state_nxt = IDLE;
        else if (timeout) state_nxt = can_retry ? DRIVE : IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fields    <= '0;
      wait_cnt  <= '0;
      retry_cnt <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= (state == WAIT_ACK) && signal_f;
      err_q  <= timeout && !can_retry;
      case (state)
        IDLE: begin
          if (in_valid) begin
            fields    <= in_data;
            retry_cnt <= '0;
          end
        end
        DRIVE: wait_cnt <= '0;
        WAIT_ACK: begin
          if (!signal_f) begin
            if (timeout) begin
              if (can_retry) retry_cnt <= retry_cnt + 2'd1;
            end else if (wait_cnt != TC) begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // outputs are held at zero for the whole reset cycle, not just after the edge
  always_comb begin
    in_ready   = 1'b0;
    drv_strobe = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    retries    = '0;
    signal_d   = '0;
    signal_e   = '0;
    signal_e2  = '0;
    signal_e3  = '0;
    if (!reset) begin
      in_ready   = (state == IDLE);
      drv_strobe = (state == DRIVE);
      done       = done_q;
      err        = err_q;
      retries    = retry_cnt;
      signal_d   = fields[12:11];
      signal_e   = fields[10:8];
      signal_e2  = fields[7:4];
      signal_e3  = fields[3:0];
    end
  end

endmodule
